// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers: per-boundary
// control bundle widths, control field offsets and the skid-buffer state encoding.
package pipe_pkg;
    localparam int IF_ID_CTRL_W  = 4;
    localparam int ID_EX_CTRL_W  = 8;
    localparam int EX_MEM_CTRL_W = 5;
    localparam int MEM_WB_CTRL_W = 3;

    // Bit offsets of the control fields inside a ctrl bundle
    localparam int CTRL_REG_WRITE = 0;
    localparam int CTRL_MEM_READ  = 1;
    localparam int CTRL_MEM_WRITE = 2;
    localparam int CTRL_BRANCH    = 3;
    localparam int CTRL_JUMP      = 4;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_t;
endpackage

// File: rtl/pipe_stage_entry.sv
// One valid+ctrl+data register. clr (flush) drops the entry and zeroes ctrl;
// data is zeroed only when CLEAR_DATA is set, otherwise it is simply held.
module pipe_stage_entry #(
    parameter int CTRL_W     = 8,
    parameter int DATA_W     = 64,
    parameter int CLEAR_DATA = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load,
    input  logic              drop,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            valid <= 1'b0;
            ctrl  <= '0;
            if (CLEAR_DATA != 0) data <= '0;
        end else if (load) begin
            valid <= 1'b1;
            ctrl  <= in_ctrl;
            data  <= in_data;
        end else if (drop) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register: valid/ready handshake, flush with bubble,
// optional skid entry for a registered in_ready, and a saturating stall counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W     = 8,
    parameter int DATA_W     = 64,
    parameter int SKID       = 0,
    parameter int CLEAR_DATA = 0,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [1:0]        occupancy
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              main_vld, main_load, main_drop;
    logic [CTRL_W-1:0] main_ctrl, main_ctrl_in;
    logic [DATA_W-1:0] main_data_in;

    pipe_stage_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CLEAR_DATA(CLEAR_DATA)) u_main (
        .clk(clk), .rst(rst), .clr(flush), .load(main_load), .drop(main_drop),
        .in_ctrl(main_ctrl_in), .in_data(main_data_in),
        .valid(main_vld), .ctrl(main_ctrl), .data(out_data)
    );

    generate
        if (SKID == 0) begin : g_single
            assign in_ready     = !main_vld || out_ready;
            assign main_load    = in_valid && in_ready;
            assign main_drop    = main_vld && out_ready;
            assign main_ctrl_in = in_ctrl;
            assign main_data_in = in_data;
            assign occupancy    = {1'b0, main_vld};
        end else begin : g_skid
            skid_state_t       state, state_nxt;
            logic              skid_vld, skid_load, skid_drop, from_skid;
            logic [CTRL_W-1:0] skid_ctrl;
            logic [DATA_W-1:0] skid_data;

            pipe_stage_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CLEAR_DATA(CLEAR_DATA)) u_skid (
                .clk(clk), .rst(rst), .clr(flush), .load(skid_load), .drop(skid_drop),
                .in_ctrl(in_ctrl), .in_data(in_data),
                .valid(skid_vld), .ctrl(skid_ctrl), .data(skid_data)
            );

            always_ff @(posedge clk) begin
                if (rst || flush) state <= ST_EMPTY;
                else              state <= state_nxt;
            end

            always_comb begin
                state_nxt = state;
                main_load = 1'b0;
                main_drop = 1'b0;
                skid_load = 1'b0;
                skid_drop = 1'b0;
                from_skid = 1'b0;
                case (state)
                    ST_EMPTY: if (in_valid) begin
                        main_load = 1'b1;
                        state_nxt = ST_ONE;
                    end
                    ST_ONE: begin
                        if (in_valid && out_ready) begin
                            main_load = 1'b1;
                        end else if (in_valid) begin
                            skid_load = 1'b1;
                            state_nxt = ST_TWO;
                        end else if (out_ready) begin
                            main_drop = 1'b1;
                            state_nxt = ST_EMPTY;
                        end
                    end
                    ST_TWO: if (out_ready) begin
                        // Skid entry is older than anything upstream: promote it
                        main_load = 1'b1;
                        from_skid = 1'b1;
                        skid_drop = 1'b1;
                        state_nxt = ST_ONE;
                    end
                    default: state_nxt = ST_EMPTY;
                endcase
            end

            assign in_ready     = (state != ST_TWO);
            assign main_ctrl_in = from_skid ? skid_ctrl : in_ctrl;
            assign main_data_in = from_skid ? skid_data : in_data;
            assign occupancy    = {1'b0, main_vld} + {1'b0, skid_vld};
        end
    endgenerate

    assign out_valid = main_vld;
    assign out_ctrl  = main_vld ? main_ctrl : '0;

    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (out_valid && !out_ready && stall_cnt != CNT_MAX)
            stall_cnt <= stall_cnt + 1'b1;
    end
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised inter-stage pipeline register, the successor to the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a control bundle and a data bundle under a valid/ready handshake. Adds per-stage stall (backpressure), flush with bubble insertion, an optional skid entry for registered ready, and a saturating stall-cycle counter.
- Each stage boundary instantiates one copy with its own widths.

Parameters:
- CTRL_W, 8, width of control bundle (RegWrite, MemRead, MemWrite, Branch, Jump, ...); zeroed on flush.
- DATA_W, 64, width of data bundle (PC, operands, immediate, register indices).
- SKID, 0, 0 = single entry with combinational in_ready; 1 = two entries with registered in_ready.
- CLEAR_DATA, 0, 1 = data bundle also zeroed on flush/reset; 0 = data held (power saving).
- CNT_W, 16, width of stall_cnt.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- flush  input  1  kill stage contents and current input
- in_valid  input  1  upstream has an entry
- in_ready  output  1  stage accepts an entry this cycle
- in_ctrl  input  CTRL_W  upstream control bundle
- in_data  input  DATA_W  upstream data bundle
- out_valid  output  1  stage holds a valid entry
- out_ready  input  1  downstream accepts (0 = stall)
- out_ctrl  output  CTRL_W  control bundle; forced 0 whenever out_valid=0
- out_data  output  DATA_W  data bundle
- stall_cnt  output  CNT_W  saturating count of stalled cycles
- occupancy  output  2  entries held (0..1 for SKID=0, 0..2 for SKID=1)

Behaviour:
- One clock (clk). Reset (rst) is synchronous and active-high.
- Reset values:
  - out_valid=0, out_ctrl=0, stall_cnt=0, occupancy=0, all internal valid bits 0.
  - out_data=0 if CLEAR_DATA=1, else unspecified-but-stable.
  - in_ready=1 in the cycle after reset.
- Handshake rules:
  - Transfer-in when in_valid&&in_ready; transfer-out when out_valid&&out_ready.
  - Latency is 1 cycle: an entry accepted at edge N appears on out_* after edge N.
  - Full throughput of 1 entry/cycle in both modes.
- SKID=0:
  - in_ready = !out_valid || out_ready (combinational).
  - On transfer-in, the main register loads in_*.
  - On transfer-out without transfer-in, out_valid clears.
- SKID=1: states EMPTY, ONE, TWO.
  - in_ready = (state != TWO); this is a register output with no combinational path from out_ready.
  - EMPTY: on in → ONE.
  - ONE:
    - in without out → TWO; the new entry goes to the skid register.
    - in with out → ONE; the main register reloads.
    - out without in → EMPTY.
  - TWO:
    - on out → ONE; the skid entry moves to main.
    - no in is possible in TWO.
  - Ordering is strictly FIFO; the skid entry never overtakes main.
- flush (synchronous, highest priority after rst):
  - Next state EMPTY; all valid bits 0; control registers 0.
  - The same-cycle incoming entry is discarded even if in_valid&&in_ready. Upstream sees the transfer as complete.
  - Data cleared only if CLEAR_DATA=1.
  - Simultaneous flush and out_ready: the downstream transfer of the current entry still completes this cycle, and the stage is empty next cycle.
- out_ctrl is gated to 0 whenever out_valid=0, so a bubble is always a NOP to downstream.
- stall_cnt:
  - Increments on each cycle with out_valid && !out_ready.
  - Saturates at 2^CNT_W-1, with no wrap.
  - Cleared only by rst; flush does not clear it.
- rst mid-operation: all entries dropped immediately at the edge, as for reset values; stall_cnt returns to 0.
- occupancy equals the number of set internal valid bits.

Decomposition:
- Shared package pipe_pkg holds:
  - the ctrl-bundle field offsets/widths for each stage boundary (ID_EX_CTRL_W, EX_MEM_CTRL_W, ...);
  - the state encoding localparams (ST_EMPTY=0, ST_ONE=1, ST_TWO=2).
- One natural sub-module: pipe_stage_entry. It is a single valid+ctrl+data register with load/clear enables, instantiated once (SKID=0) or twice (SKID=1).
- Counter logic stays inline.

Test Plan:
- SKID=0, in_valid=1 with ctrl=0x5A and data=0x1234 for 3 cycles, out_ready=1 → out_* shows the same values 1 cycle later, each cycle; stall_cnt=0.
- SKID=1, fill with A=0x11, B=0x22 while out_ready=0 → occupancy=2, in_ready=0, stall_cnt=1 after the first stalled cycle. Then raise out_ready → out_data A then B in order, and in_ready returns to 1 after the first drain.
- flush asserted in state TWO together with in_valid=1 (data 0x33) → next cycle out_valid=0, out_ctrl=0, occupancy=0. 0x33 never appears on the output.
- flush with out_valid=1 and out_ready=1 → the current entry counts as transferred. The following cycle is a bubble with ctrl=0.
- CNT_W=4, hold out_valid=1 with out_ready=0 for 20 cycles → stall_cnt saturates at 15; a later flush leaves it at 15; rst clears it to 0.
- rst asserted while SKID=1 holds 2 entries and in_valid=1 → next cycle out_valid=0, occupancy=0, in_ready=1.
